fetch_pc_ctrl: RTL and testbench

- Upstream neighbour of the combinational Y86-64 fetch stage.
- Holds the F pipeline register (predicted PC) and performs PC selection, driving the fetch PC input each cycle.
- Contains the pipeline-control FSM: ret wait, mispredict recovery, load-use stall, halt-on-bad-fetch.
- Emits stall/bubble controls to the F/D/E pipeline registers.

---
 rtl/fetch_pc_ctrl.sv | 157 +++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_ctrl.sv
// Y86-64 fetch PC selection, F pipeline register and pipeline-control FSM.
// Optional performance counters are built when PC_CTRL_PERF_EN is defined.
module fetch_pc_ctrl #(
  parameter int unsigned    XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] f_predPC_i,
  input  logic [3:0]      f_icode_i,
  input  logic [2:0]      f_stat_i,
  input  logic [3:0]      d_srcA_i,
  input  logic [3:0]      d_srcB_i,
  input  logic [3:0]      E_icode_i,
  input  logic [3:0]      E_dstM_i,
  input  logic            e_Cnd_i,
  input  logic [3:0]      M_icode_i,
  input  logic            M_Cnd_i,
  input  logic [XLEN-1:0] M_valA_i,
  input  logic [3:0]      W_icode_i,
  input  logic [XLEN-1:0] W_valM_i,
  output logic [XLEN-1:0] pc_o,
  output logic            F_stall_o,
  output logic            D_stall_o,
  output logic            D_bubble_o,
  output logic            E_bubble_o,
`ifdef PC_CTRL_PERF_EN
  output logic [31:0]     stall_cnt_o,
  output logic [31:0]     bubble_cnt_o,
  output logic [31:0]     ret_cnt_o,
`endif
  output logic            halted_o
);

  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] SAOK    = 3'd1;

  typedef enum logic [1:0] {StRun, StRetWait, StHalt} state_e;

  state_e          r_state;
  state_e          w_next_state;
  logic [XLEN-1:0] r_pred_pc;
  logic            w_mispredict;
  logic            w_load_use;
  logic            w_ret_done;

  assign w_mispredict = (E_icode_i == IJXX) && !e_Cnd_i;
  assign w_load_use   = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) &&
                        (E_dstM_i != RNONE) &&
                        ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));

  always_comb begin
    if ((M_icode_i == IJXX) && !M_Cnd_i) begin
      pc_o = M_valA_i;
    end else if (W_icode_i == IRET) begin
      pc_o = W_valM_i;
    end else begin
      pc_o = r_pred_pc;
    end
  end

  always_comb begin
    w_next_state = r_state;
    F_stall_o    = 1'b0;
    D_stall_o    = 1'b0;
    D_bubble_o   = 1'b0;
    E_bubble_o   = 1'b0;
    // A mispredict squashes everything younger, including speculative ret/halt waits.
    if (w_mispredict) begin
      D_bubble_o   = 1'b1;
      E_bubble_o   = 1'b1;
      w_next_state = StRun;
    end else begin
      if (w_load_use) begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        E_bubble_o = 1'b1;
      end
      case (r_state)
        StRun: begin
          if (!F_stall_o) begin
            if (f_stat_i != SAOK) begin
              w_next_state = StHalt;
            end else if (f_icode_i == IRET) begin
              w_next_state = StRetWait;
            end
          end
        end
        StRetWait: begin
          if (W_icode_i == IRET) begin
            w_next_state = StRun;
          end else begin
            F_stall_o  = 1'b1;
            D_bubble_o = !D_stall_o;
          end
        end
        StHalt: begin
          F_stall_o  = 1'b1;
          D_bubble_o = !D_stall_o;
        end
        default: w_next_state = StRun;
      endcase
    end
  end

  assign halted_o   = (r_state == StHalt);
  assign w_ret_done = (r_state == StRetWait) && (w_next_state == StRun);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StRun;
      r_pred_pc <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      if (!F_stall_o) begin
        r_pred_pc <= f_predPC_i;
      end
    end
  end

`ifdef PC_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_ret_cnt;

  // Counters saturate rather than wrap so long runs stay monotonic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
      r_ret_cnt    <= '0;
    end else begin
      if (F_stall_o && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if ((D_bubble_o || E_bubble_o) && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
      if (w_ret_done && (r_ret_cnt != 32'hFFFF_FFFF)) begin
        r_ret_cnt <= r_ret_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt_o  = r_stall_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
  assign ret_cnt_o    = r_ret_cnt;
`else
  logic w_unused;
  assign w_unused = w_ret_done;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios, then random stimulus
// compared against a behavioural model of the pipeline-control rules.
module tb_fetch_pc_ctrl;

  localparam logic [3:0] INOP = 4'h1, IOPQ = 4'h6, IMRMOVQ = 4'h5, IJXX = 4'h7;
  localparam logic [3:0] IRET = 4'h9, IPOPQ = 4'hB;
  localparam logic [2:0] SAOK = 3'd1, SINS = 3'd3, SHLT = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] f_predPC_i, M_valA_i, W_valM_i;
  logic [3:0]  f_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, M_icode_i, W_icode_i;
  logic [2:0]  f_stat_i;
  logic        e_Cnd_i, M_Cnd_i;
  logic [63:0] pc_o;
  logic        F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, halted_o;
`ifdef PC_CTRL_PERF_EN
  logic [31:0] stall_cnt_o, bubble_cnt_o, ret_cnt_o;
`endif

  fetch_pc_ctrl #(.XLEN(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_predPC_i(f_predPC_i), .f_icode_i(f_icode_i), .f_stat_i(f_stat_i),
    .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
    .E_icode_i(E_icode_i), .E_dstM_i(E_dstM_i), .e_Cnd_i(e_Cnd_i),
    .M_icode_i(M_icode_i), .M_Cnd_i(M_Cnd_i), .M_valA_i(M_valA_i),
    .W_icode_i(W_icode_i), .W_valM_i(W_valM_i),
    .pc_o(pc_o), .F_stall_o(F_stall_o), .D_stall_o(D_stall_o),
    .D_bubble_o(D_bubble_o), .E_bubble_o(E_bubble_o),
`ifdef PC_CTRL_PERF_EN
    .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o), .ret_cnt_o(ret_cnt_o),
`endif
    .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: what the pipeline is waiting for, plus the predicted PC.
  logic [63:0] m_pred;
  bit          m_wait_ret, m_halted;
  int unsigned m_stalls, m_bubbles, m_rets;
  logic [63:0] x_pc;
  bit          x_fst, x_dst, x_db, x_eb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pred = 64'h0; m_wait_ret = 0; m_halted = 0;
    m_stalls = 0; m_bubbles = 0; m_rets = 0;
  endtask

  task automatic model_eval();
    bit mis, lu, blocked;
    mis     = (E_icode_i == IJXX) && !e_Cnd_i;
    lu      = (E_icode_i == IMRMOVQ || E_icode_i == IPOPQ) && E_dstM_i != 4'hF &&
              (E_dstM_i == d_srcA_i || E_dstM_i == d_srcB_i);
    blocked = (m_wait_ret && W_icode_i != IRET) || m_halted;
    if (mis) begin
      x_fst = 0; x_dst = 0; x_db = 1; x_eb = 1;
    end else begin
      x_fst = lu || blocked; x_dst = lu; x_db = blocked && !lu; x_eb = lu;
    end
    if (M_icode_i == IJXX && !M_Cnd_i) x_pc = M_valA_i;
    else if (W_icode_i == IRET)        x_pc = W_valM_i;
    else                               x_pc = m_pred;
  endtask

  task automatic model_update();
    bit mis;
    model_eval();
    mis = (E_icode_i == IJXX) && !e_Cnd_i;
    if (x_fst && m_stalls != 32'hFFFF_FFFF) m_stalls++;
    if ((x_db || x_eb) && m_bubbles != 32'hFFFF_FFFF) m_bubbles++;
    if (!x_fst) m_pred = f_predPC_i;
    if (mis) begin
      if (m_wait_ret) m_rets++;
      m_wait_ret = 0; m_halted = 0;
    end else if (m_halted) begin
      m_halted = 1;
    end else if (m_wait_ret) begin
      if (W_icode_i == IRET) begin
        m_wait_ret = 0; m_rets++;
      end
    end else if (!x_fst) begin
      if (f_stat_i != SAOK) m_halted = 1;
      else if (f_icode_i == IRET) m_wait_ret = 1;
    end
  endtask

  // Compare every output against the model at the falling edge.
  task automatic sample(input string tag);
    @(negedge clk);
    model_eval();
    chk({tag, ".pc"},       pc_o,       x_pc);
    chk({tag, ".F_stall"},  F_stall_o,  x_fst);
    chk({tag, ".D_stall"},  D_stall_o,  x_dst);
    chk({tag, ".D_bubble"}, D_bubble_o, x_db);
    chk({tag, ".E_bubble"}, E_bubble_o, x_eb);
    chk({tag, ".halted"},   halted_o,   m_halted);
`ifdef PC_CTRL_PERF_EN
    chk({tag, ".stall_cnt"},  stall_cnt_o,  m_stalls);
    chk({tag, ".bubble_cnt"}, bubble_cnt_o, m_bubbles);
    chk({tag, ".ret_cnt"},    ret_cnt_o,    m_rets);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    f_icode_i = INOP; f_stat_i = SAOK;
    d_srcA_i = 4'hF; d_srcB_i = 4'hF;
    E_icode_i = INOP; E_dstM_i = 4'hF; e_Cnd_i = 1'b1;
    M_icode_i = INOP; M_Cnd_i = 1'b1; M_valA_i = 64'h0;
    W_icode_i = INOP; W_valM_i = 64'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst.pc", pc_o, 64'h0);
    chk("rst.F_stall", F_stall_o, 1'b0);
    chk("rst.D_bubble", D_bubble_o, 1'b0);
    chk("rst.halted", halted_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  logic [3:0] e_set [6] = '{INOP, IMRMOVQ, IJXX, IPOPQ, IRET, IOPQ};
  logic [3:0] f_set [3] = '{INOP, IRET, IOPQ};

  initial begin
    logic [63:0] held_pc;
    idle_inputs();
    f_predPC_i = 64'h0A;
    do_reset();

    // Cycle 1: F register now holds the predicted PC from fetch.
    f_predPC_i = 64'h14;
    sample("c1");
    chk("c1.pc_0A", pc_o, 64'h0A);
    tick();
    for (int i = 0; i < 3; i++) begin
      f_predPC_i = 64'h20 + 64'(i);
      sample("run");
      tick();
    end

    // ret fetched: three stalled cycles, then the return address from W.
    f_icode_i = IRET; f_predPC_i = 64'h40;
    sample("ret_fetch");
    chk("ret_fetch.F_stall", F_stall_o, 1'b0);
    tick();
    f_icode_i = INOP; f_predPC_i = 64'h99;
    for (int i = 0; i < 3; i++) begin
      sample("ret_wait");
      chk("ret_wait.F_stall_1", F_stall_o, 1'b1);
      chk("ret_wait.D_bubble_1", D_bubble_o, 1'b1);
      tick();
    end
    W_icode_i = IRET; W_valM_i = 64'hDD; f_predPC_i = 64'hE0;
    sample("ret_w");
    chk("ret_w.pc_DD", pc_o, 64'hDD);
    chk("ret_w.F_stall_0", F_stall_o, 1'b0);
    tick();
    W_icode_i = INOP;
    sample("ret_done");
    chk("ret_done.pc", pc_o, 64'hE0);
    chk("ret_done.F_stall_0", F_stall_o, 1'b0);
`ifdef PC_CTRL_PERF_EN
    chk("ret_done.stall_cnt_3", stall_cnt_o, 32'd3);
    chk("ret_done.ret_cnt_1", ret_cnt_o, 32'd1);
`endif
    tick();

    // Mispredicted jump: bubbles now, fall-through PC next cycle.
    E_icode_i = IJXX; e_Cnd_i = 1'b0;
    sample("mis_e");
    chk("mis_e.D_bubble", D_bubble_o, 1'b1);
    chk("mis_e.E_bubble", E_bubble_o, 1'b1);
    tick();
    E_icode_i = INOP; e_Cnd_i = 1'b1;
    M_icode_i = IJXX; M_Cnd_i = 1'b0; M_valA_i = 64'h5B;
    sample("mis_m");
    chk("mis_m.pc_5B", pc_o, 64'h5B);
    tick();
    M_icode_i = INOP; M_Cnd_i = 1'b1;

    // Load-use hazard: one-cycle stall, F register unchanged.
    E_icode_i = IMRMOVQ; E_dstM_i = 4'd3; d_srcB_i = 4'd3; f_predPC_i = 64'h77;
    sample("lu");
    held_pc = m_pred;
    chk("lu.F_stall", F_stall_o, 1'b1);
    chk("lu.D_stall", D_stall_o, 1'b1);
    chk("lu.E_bubble", E_bubble_o, 1'b1);
    chk("lu.D_bubble_0", D_bubble_o, 1'b0);
    tick();
    E_icode_i = INOP; E_dstM_i = 4'hF; d_srcB_i = 4'hF;
    sample("lu_after");
    chk("lu_after.pc_held", pc_o, held_pc);
    tick();

    // Bad fetch status halts; a mispredict recovers.
    f_stat_i = SINS;
    sample("bad_fetch");
    tick();
    f_stat_i = SAOK;
    for (int i = 0; i < 2; i++) begin
      sample("halt");
      chk("halt.halted_1", halted_o, 1'b1);
      chk("halt.F_stall_1", F_stall_o, 1'b1);
      tick();
    end
    E_icode_i = IJXX; e_Cnd_i = 1'b0;
    sample("halt_mis");
    tick();
    E_icode_i = INOP; e_Cnd_i = 1'b1;
    sample("halt_exit");
    chk("halt_exit.halted_0", halted_o, 1'b0);
    tick();

    // Reset while halted.
    f_stat_i = SHLT;
    sample("halt2");
    tick();
    f_stat_i = SAOK;
    sample("halt2_in");
    chk("halt2_in.halted_1", halted_o, 1'b1);
    do_reset();
    sample("post_rst");

    // Random phase against the model.
    for (int i = 0; i < 600; i++) begin
      f_predPC_i = {$urandom, $urandom};
      f_icode_i  = f_set[$urandom_range(2, 0)];
      f_stat_i   = ($urandom_range(15, 0) == 0) ? 3'($urandom_range(4, 2)) : SAOK;
      d_srcA_i   = 4'($urandom_range(15, 0));
      d_srcB_i   = 4'($urandom_range(15, 0));
      E_icode_i  = e_set[$urandom_range(5, 0)];
      E_dstM_i   = 4'($urandom_range(15, 0));
      e_Cnd_i    = 1'($urandom_range(1, 0));
      M_icode_i  = $urandom_range(1, 0) ? IJXX : INOP;
      M_Cnd_i    = 1'($urandom_range(1, 0));
      M_valA_i   = {$urandom, $urandom};
      W_icode_i  = ($urandom_range(3, 0) == 0) ? IRET : INOP;
      W_valM_i   = {$urandom, $urandom};
      sample("rand");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
